// File: rtl/vga_scan_timing.sv
// VGA raster timing: free-running h/v counters, registered coordinates for the
// drawing stages, and a one-clock output stage that blanks RGB and aligns sync.
module vga_scan_timing #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 48,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 248,
  parameter int   V_ACTIVE = 1024,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 38,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  output logic [11:0] VGA_HORZ_COORD,
  output logic [11:0] VGA_VERT_COORD,
  output logic        FRAME_START,
  input  logic [3:0]  VGA_RED_IN,
  input  logic [3:0]  VGA_GREEN_IN,
  input  logic [3:0]  VGA_BLUE_IN,
  output logic [3:0]  VGA_RED,
  output logic [3:0]  VGA_GREEN,
  output logic [3:0]  VGA_BLUE,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_q, h_d, v_q, v_d;
  logic        run_q;
  logic        fs_d, fs_q;
  logic        active, hs0, vs0;
  logic [3:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q;

  // After reset the counters hold at (0,0) for one extra edge so that the
  // first post-reset cycle presents the frame origin with FRAME_START high.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = 12'd0;
        v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      end else begin
        h_d = h_q + 12'd1;
      end
    end
    fs_d = (h_d == 12'd0) && (v_d == 12'd0);
  end

  always_comb begin
    active = (h_q < H_ACT) && (v_q < V_ACT) && run_q;
    hs0    = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs0    = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      h_q   <= 12'd0;
      v_q   <= 12'd0;
      run_q <= 1'b0;
      fs_q  <= 1'b0;
      r_q   <= 4'h0;
      g_q   <= 4'h0;
      b_q   <= 4'h0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      run_q <= 1'b1;
      fs_q  <= fs_d;
      r_q   <= active ? VGA_RED_IN   : 4'h0;
      g_q   <= active ? VGA_GREEN_IN : 4'h0;
      b_q   <= active ? VGA_BLUE_IN  : 4'h0;
      hs_q  <= hs0;
      vs_q  <= vs0;
    end
  end

  assign VGA_HORZ_COORD = h_q;
  assign VGA_VERT_COORD = v_q;
  assign FRAME_START    = fs_q;
  assign VGA_RED        = r_q;
  assign VGA_GREEN      = g_q;
  assign VGA_BLUE       = b_q;
  assign VGA_HS         = hs_q;
  assign VGA_VS         = vs_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing on a reduced raster: two builds (positive and
// negative sync) checked cycle by cycle against a cycle-count raster model.
module tb_vga_scan_timing;

  localparam int HA = 16, HF = 3, HSW = 5, HB = 4;
  localparam int VA = 10, VF = 1, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] r_in, g_in, b_in;

  logic [11:0] p_h, p_v, n_h, n_v;
  logic        p_fs, n_fs, p_hs, p_vs, n_hs, n_vs;
  logic [3:0]  p_r, p_g, p_b, n_r, n_g, n_b;

  always #5 clk = ~clk;

  vga_scan_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                    .SYNC_POL(1'b1)) u_pos (
    .CLK_VGA(clk), .RESET(rst),
    .VGA_HORZ_COORD(p_h), .VGA_VERT_COORD(p_v), .FRAME_START(p_fs),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_RED(p_r), .VGA_GREEN(p_g), .VGA_BLUE(p_b),
    .VGA_HS(p_hs), .VGA_VS(p_vs));

  vga_scan_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                    .SYNC_POL(1'b0)) u_neg (
    .CLK_VGA(clk), .RESET(rst),
    .VGA_HORZ_COORD(n_h), .VGA_VERT_COORD(n_v), .FRAME_START(n_fs),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_RED(n_r), .VGA_GREEN(n_g), .VGA_BLUE(n_b),
    .VGA_HS(n_hs), .VGA_VS(n_vs));

  int total = 0;
  int bad   = 0;
  int t;
  bit use_const;
  logic [3:0] const_val;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    if (use_const) begin
      r_in = const_val; g_in = const_val; b_in = const_val;
    end else begin
      r_in = 4'($urandom); g_in = 4'($urandom); b_in = 4'($urandom);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_h", 16'(p_h), 16'd0);
    chk("rst_v", 16'(p_v), 16'd0);
    chk("rst_fs", 16'(p_fs), 16'd0);
    chk("rst_rgb", 16'({p_r, p_g, p_b}), 16'd0);
    chk("rst_sync_pos", 16'({p_hs, p_vs}), 16'b00);
    chk("rst_sync_neg", 16'({n_hs, n_vs}), 16'b11);
    chk("rst_fs_neg", 16'(n_fs), 16'd0);
  endtask

  task automatic chk_origin();
    chk("start_h", 16'(p_h), 16'd0);
    chk("start_v", 16'(p_v), 16'd0);
    chk("start_fs", 16'(p_fs), 16'd1);
    chk("start_fs_neg", 16'(n_fs), 16'd1);
  endtask

  // One raster clock: remember what is being presented, advance, then check
  // coordinates for the new cycle and pins for the previous coordinates.
  task automatic run_cycle();
    int hp, vp;
    logic [3:0] rp, gp, bp, er, eg, eb;
    bit act, hsa, vsa;
    hp = t % HT;
    vp = (t / HT) % VT;
    rp = r_in; gp = g_in; bp = b_in;
    @(posedge clk);
    #1;
    t++;
    chk("h", 16'(p_h), 16'(t % HT));
    chk("v", 16'(p_v), 16'((t / HT) % VT));
    chk("fs", 16'(p_fs), 16'((t % FT) == 0));
    chk("n_hv", 16'({n_h[7:0], n_v[7:0]}), 16'({8'(t % HT), 8'((t / HT) % VT)}));
    act = (hp < HA) && (vp < VA);
    er = act ? rp : 4'h0;
    eg = act ? gp : 4'h0;
    eb = act ? bp : 4'h0;
    hsa = (hp >= HA + HF) && (hp < HA + HF + HSW);
    vsa = (vp >= VA + VF) && (vp < VA + VF + VSW);
    chk("rgb", 16'({p_r, p_g, p_b}), 16'({er, eg, eb}));
    chk("rgb_neg", 16'({n_r, n_g, n_b}), 16'({er, eg, eb}));
    chk("hs_pos", 16'(p_hs), 16'(hsa));
    chk("vs_pos", 16'(p_vs), 16'(vsa));
    chk("hs_neg", 16'(n_hs), 16'(!hsa));
    chk("vs_neg", 16'(n_vs), 16'(!vsa));
    drive_inputs();
  endtask

  initial begin
    int hs_cnt;
    use_const = 1'b0;
    const_val = 4'h0;
    t = 0;
    rst = 1'b1;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();

    rst = 1'b0;
    @(posedge clk);
    #1;
    t = 0;
    chk_origin();
    drive_inputs();

    // Random pixels for two full frames plus part of a third.
    repeat (2 * FT + 20) run_cycle();

    // Constant 4'hF across one frame: blanking must hold regardless of input.
    use_const = 1'b1;
    const_val = 4'hF;
    drive_inputs();
    hs_cnt = 0;
    repeat (FT) begin
      run_cycle();
      if (p_hs) hs_cnt++;
    end
    chk("hs_per_frame", 16'(hs_cnt), 16'(HSW * VT));
    use_const = 1'b0;
    drive_inputs();

    // Reset mid-line in the active area.
    while ((t % FT) != 5 * HT + 7) run_cycle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1;
    t = 0;
    chk_origin();
    drive_inputs();

    repeat (FT + 5) run_cycle();

    // Reset held for several clocks during vertical sync.
    while ((t % FT) != (VA + VF) * HT + 2) run_cycle();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    @(posedge clk);
    #1;
    t = 0;
    chk_origin();
    drive_inputs();
    repeat (HT * 3) run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
